// File: rtl/sad_pkg.sv
// Shared definitions for the parametrised SAD/SSD engine: FSM state encoding,
// mode constants and the per-pixel term width helper.
package sad_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic MODE_SAD = 1'b0;
  localparam logic MODE_SSD = 1'b1;

  // A squared DATA_W-bit difference needs twice the pixel width.
  function automatic int term_width(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/sad_diff_term.sv
// Combinational per-pixel term: |a-b| in SAD mode, (a-b)^2 in SSD mode,
// zero-extended to the full term width.
module sad_diff_term
  import sad_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TERM_W = term_width(DATA_W)
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mode,
  output logic [TERM_W-1:0] term
);

  logic [DATA_W-1:0] diff;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    diff = (a >= b) ? (a - b) : (b - a);
    term = (mode == MODE_SSD) ? (TERM_W'(diff) * TERM_W'(diff)) : TERM_W'(diff);
  end

endmodule

// File: rtl/sad_engine_param.sv
// Pipelined SAD/SSD engine: streams NUM_BLOCKS blocks of BLOCK_SIZE pixel pairs
// and writes one saturating sum per block. Optional macro SAD_MIN_TRACK_EN adds
// Min_Sad/Min_Idx tracking of the smallest block result of a run.
module sad_engine_param
  import sad_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 15,
  parameter int OUT_ADDR_W = 7,
  parameter int BLOCK_SIZE = 256,
  parameter int NUM_BLOCKS = 128,
  parameter int RD_LAT     = 2,
  parameter int SUM_W      = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Go,
  input  logic                  Mode,
  input  logic [ADDR_W-1:0]     A_Base,
  input  logic [ADDR_W-1:0]     B_Base,
  output logic [ADDR_W-1:0]     A_Addr,
  output logic [ADDR_W-1:0]     B_Addr,
  output logic                  I_En,
  output logic                  I_RW,
  input  logic [DATA_W-1:0]     A_Data,
  input  logic [DATA_W-1:0]     B_Data,
  output logic [OUT_ADDR_W-1:0] C_Addr,
  output logic                  O_En,
  output logic                  O_RW,
  output logic [SUM_W-1:0]      SAD_Out,
  output logic                  Busy,
  output logic                  Done
`ifdef SAD_MIN_TRACK_EN
  ,
  output logic [SUM_W-1:0]      Min_Sad,
  output logic [OUT_ADDR_W-1:0] Min_Idx
`endif
);

  localparam int TERM_W    = term_width(DATA_W);
  localparam int J_W       = $clog2(BLOCK_SIZE + 1);
  localparam int D_W       = $clog2(RD_LAT + 1);
  localparam int SUM_EXT_W = ((SUM_W > TERM_W) ? SUM_W : TERM_W) + 1;

  localparam logic [J_W-1:0]        J_LAST  = J_W'(BLOCK_SIZE);
  localparam logic [D_W-1:0]        D_LAST  = D_W'(RD_LAT - 1);
  localparam logic [OUT_ADDR_W-1:0] K_LAST  = OUT_ADDR_W'(NUM_BLOCKS - 1);
  localparam logic [SUM_W-1:0]      SUM_MAX = '1;

  state_t                  state;
  logic                    mode_q;
  logic [ADDR_W-1:0]       a_base_q;
  logic [ADDR_W-1:0]       b_base_q;
  logic [ADDR_W-1:0]       offset;
  logic [J_W-1:0]          j;
  logic [D_W-1:0]          d_cnt;
  logic [OUT_ADDR_W-1:0]   k;
  logic [SUM_W-1:0]        acc;
  logic [RD_LAT-1:0]       vpipe;
  logic                    vld;
  logic [TERM_W-1:0]       term;
  logic [SUM_EXT_W-1:0]    sum_ext;
  logic [SUM_W-1:0]        acc_sat;

  assign I_RW = 1'b0;
  assign vld  = vpipe[RD_LAT-1];

  sad_diff_term #(
    .DATA_W(DATA_W),
    .TERM_W(TERM_W)
  ) u_term (
    .a   (A_Data),
    .b   (B_Data),
    .mode(mode_q),
    .term(term)
  );

  // Extra headroom bit catches overflow whether the accumulator or the term is wider.
  always_comb begin
    sum_ext = SUM_EXT_W'(acc) + SUM_EXT_W'(term);
    acc_sat = (sum_ext > SUM_EXT_W'(SUM_MAX)) ? SUM_MAX : sum_ext[SUM_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      mode_q   <= MODE_SAD;
      a_base_q <= '0;
      b_base_q <= '0;
      offset   <= '0;
      j        <= '0;
      d_cnt    <= '0;
      k        <= '0;
      acc      <= '0;
      vpipe    <= '0;
      A_Addr   <= '0;
      B_Addr   <= '0;
      I_En     <= 1'b0;
      C_Addr   <= '0;
      O_En     <= 1'b0;
      O_RW     <= 1'b0;
      SAD_Out  <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
`ifdef SAD_MIN_TRACK_EN
      Min_Sad  <= '0;
      Min_Idx  <= '0;
`endif
    end else begin
      vpipe <= (vpipe << 1) | RD_LAT'(I_En);
      if (vld) acc <= acc_sat;
      Done <= 1'b0;

      case (state)
        IDLE: begin
          // A Go arriving while Done is still high is ignored for that cycle.
          if (Go && !Done) begin
            state    <= INIT;
            Busy     <= 1'b1;
            mode_q   <= Mode;
            a_base_q <= A_Base;
            b_base_q <= B_Base;
            k        <= '0;
            offset   <= '0;
`ifdef SAD_MIN_TRACK_EN
            Min_Sad  <= SUM_MAX;
            Min_Idx  <= '0;
`endif
          end
        end

        INIT: begin
          acc    <= '0;
          I_En   <= 1'b1;
          A_Addr <= a_base_q + offset;
          B_Addr <= b_base_q + offset;
          offset <= offset + 1'b1;
          j      <= J_W'(1);
          state  <= RUN;
        end

        RUN: begin
          if (j == J_LAST) begin
            I_En  <= 1'b0;
            d_cnt <= '0;
            state <= DRAIN;
          end else begin
            A_Addr <= a_base_q + offset;
            B_Addr <= b_base_q + offset;
            offset <= offset + 1'b1;
            j      <= j + 1'b1;
          end
        end

        DRAIN: begin
          if (d_cnt == D_LAST) begin
            // The final term may land on this same edge, so fold it in here.
            state   <= WRITE;
            O_En    <= 1'b1;
            O_RW    <= 1'b1;
            C_Addr  <= k;
            SAD_Out <= vld ? acc_sat : acc;
          end else begin
            d_cnt <= d_cnt + 1'b1;
          end
        end

        WRITE: begin
          O_En    <= 1'b0;
          O_RW    <= 1'b0;
          C_Addr  <= '0;
          SAD_Out <= '0;
`ifdef SAD_MIN_TRACK_EN
          if (acc < Min_Sad) begin
            Min_Sad <= acc;
            Min_Idx <= k;
          end
`endif
          if (k == K_LAST) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            k     <= k + 1'b1;
            state <= INIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_engine_param.sv
// Directed self-checking bench for sad_engine_param: a 4-block main instance and
// an 8-bit-accumulator single-block instance, each fed by a 2-cycle-latency memory.
module tb_sad_engine_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, go_main, go_sat, mode;
  logic [14:0] a_base, b_base;

  logic [14:0] m_a_addr, m_b_addr, s_a_addr, s_b_addr;
  logic        m_i_en, m_i_rw, m_o_en, m_o_rw, m_busy, m_done;
  logic        s_i_en, s_i_rw, s_o_en, s_o_rw, s_busy, s_done;
  logic [7:0]  m_a_data, m_b_data, s_a_data, s_b_data;
  logic [6:0]  m_c_addr, s_c_addr;
  logic [31:0] m_sad;
  logic [7:0]  s_sad;
`ifdef SAD_MIN_TRACK_EN
  logic [31:0] m_min_sad;
  logic [6:0]  m_min_idx, s_min_idx;
  logic [7:0]  s_min_sad;
`endif

  sad_engine_param #(.BLOCK_SIZE(4), .NUM_BLOCKS(4), .RD_LAT(2), .SUM_W(32)) u_main (
    .Clk(clk), .Rst_n(rst_n), .Go(go_main), .Mode(mode), .A_Base(a_base), .B_Base(b_base),
    .A_Addr(m_a_addr), .B_Addr(m_b_addr), .I_En(m_i_en), .I_RW(m_i_rw),
    .A_Data(m_a_data), .B_Data(m_b_data), .C_Addr(m_c_addr), .O_En(m_o_en), .O_RW(m_o_rw),
    .SAD_Out(m_sad), .Busy(m_busy), .Done(m_done)
`ifdef SAD_MIN_TRACK_EN
    , .Min_Sad(m_min_sad), .Min_Idx(m_min_idx)
`endif
  );

  sad_engine_param #(.BLOCK_SIZE(4), .NUM_BLOCKS(1), .RD_LAT(2), .SUM_W(8)) u_sat (
    .Clk(clk), .Rst_n(rst_n), .Go(go_sat), .Mode(mode), .A_Base(a_base), .B_Base(b_base),
    .A_Addr(s_a_addr), .B_Addr(s_b_addr), .I_En(s_i_en), .I_RW(s_i_rw),
    .A_Data(s_a_data), .B_Data(s_b_data), .C_Addr(s_c_addr), .O_En(s_o_en), .O_RW(s_o_rw),
    .SAD_Out(s_sad), .Busy(s_busy), .Done(s_done)
`ifdef SAD_MIN_TRACK_EN
    , .Min_Sad(s_min_sad), .Min_Idx(s_min_idx)
`endif
  );

  // Shared frame memories with a two-register read path per instance.
  logic [7:0] mem_a [32768];
  logic [7:0] mem_b [32768];
  logic [7:0] ma1, ma2, mb1, mb2, sa1, sa2, sb1, sb2;
  always @(posedge clk) begin
    ma1 <= mem_a[m_a_addr]; ma2 <= ma1;
    mb1 <= mem_b[m_b_addr]; mb2 <= mb1;
    sa1 <= mem_a[s_a_addr]; sa2 <= sa1;
    sb1 <= mem_b[s_b_addr]; sb2 <= sb1;
  end
  assign m_a_data = ma2;
  assign m_b_data = mb2;
  assign s_a_data = sa2;
  assign s_b_data = sb2;

  logic        sel_sat;
  logic        obs_i_en, obs_o_en, obs_done;
  logic [14:0] obs_a_addr, obs_b_addr;
  logic [6:0]  obs_c_addr;
  logic [31:0] obs_sad;
  assign obs_i_en   = sel_sat ? s_i_en : m_i_en;
  assign obs_o_en   = sel_sat ? s_o_en : m_o_en;
  assign obs_done   = sel_sat ? s_done : m_done;
  assign obs_a_addr = sel_sat ? s_a_addr : m_a_addr;
  assign obs_b_addr = sel_sat ? s_b_addr : m_b_addr;
  assign obs_c_addr = sel_sat ? s_c_addr : m_c_addr;
  assign obs_sad    = sel_sat ? 32'(s_sad) : m_sad;

  int errors = 0;
  int checks = 0;

  int          n_iss, n_w, n_done, done_cyc, overlap, n_evt;
  logic [14:0] iss_a [64];
  logic [14:0] iss_b [64];
  logic [6:0]  w_addr [8];
  logic [31:0] w_sum [8];
  int          w_cyc [8];
  logic [31:0] min_sad_done;
  logic [6:0]  min_idx_done;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Starts one run, scrambles the latched inputs afterwards and records every
  // issue, write and Done seen on the negative edge. cyc counts edges since Go.
  task automatic run(input bit on_sat, input bit md, input logic [14:0] ab, input logic [14:0] bb,
                     input int go_again, input bit go_at_done);
    n_iss = 0; n_w = 0; n_done = 0; done_cyc = -1; overlap = 0;
    sel_sat = on_sat; mode = md; a_base = ab; b_base = bb;
    @(negedge clk);
    if (on_sat) go_sat = 1'b1; else go_main = 1'b1;
    @(negedge clk);
    go_sat = 1'b0; go_main = 1'b0;
    mode = ~md; a_base = ~ab; b_base = ~bb;
    for (int cyc = 1; cyc <= 400 && n_done == 0; cyc++) begin
      if (obs_i_en && n_iss < 64) begin
        iss_a[n_iss] = obs_a_addr; iss_b[n_iss] = obs_b_addr; n_iss++;
      end
      if (obs_o_en && n_w < 8) begin
        w_addr[n_w] = obs_c_addr; w_sum[n_w] = obs_sad; w_cyc[n_w] = cyc; n_w++;
      end
      if (obs_o_en && obs_done) overlap++;
      if (obs_done) begin
        n_done++; done_cyc = cyc;
`ifdef SAD_MIN_TRACK_EN
        min_sad_done = m_min_sad; min_idx_done = m_min_idx;
`endif
      end
      if ((cyc == go_again) || (go_at_done && obs_done)) begin
        if (on_sat) go_sat = 1'b1; else go_main = 1'b1;
      end else begin
        go_sat = 1'b0; go_main = 1'b0;
      end
      @(negedge clk);
    end
    check("run_done_seen", 64'(n_done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; go_main = 1'b0; go_sat = 1'b0; mode = 1'b0;
    a_base = '0; b_base = '0; sel_sat = 1'b0;
    for (int i = 0; i < 32768; i++) begin mem_a[i] = 8'd0; mem_b[i] = 8'd0; end
    mem_a[15'h1000] = 8'd10; mem_a[15'h1001] = 8'd20; mem_a[15'h1002] = 8'd30; mem_a[15'h1003] = 8'd40;
    mem_b[15'h2000] = 8'd12; mem_b[15'h2001] = 8'd15; mem_b[15'h2002] = 8'd30; mem_b[15'h2003] = 8'd50;
    for (int i = 0; i < 16; i++) mem_a[(15'h7FFE + i) & 15'h7FFF] = 8'(i + 1);
    mem_a[15'h3000] = 8'd50; mem_a[15'h3004] = 8'd20; mem_b[15'h3009 + 15'h1000] = 8'd20;
    mem_a[15'h300C] = 8'd70;
    for (int i = 0; i < 4; i++) mem_a[15'h5000 + i] = 8'd255;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(m_busy), 64'd0);
    check("rst_i_en", 64'(m_i_en), 64'd0);
    check("rst_o_en", 64'(m_o_en), 64'd0);
    check("rst_rw", 64'({m_i_rw, m_o_rw, s_i_rw, s_o_rw}), 64'd0);
    check("rst_sad", 64'(m_sad), 64'd0);
    check("rst_sat_busy", 64'(s_busy), 64'd0);
    rst_n = 1'b1;

    // SAD of block 0: 2+5+0+10 = 17; other blocks read zeros.
    run(1'b0, 1'b0, 15'h1000, 15'h2000, 0, 1'b0);
    check("sad_writes", 64'(n_w), 64'd4);
    check("sad_blk0", 64'(w_sum[0]), 64'd17);
    check("sad_blk0_addr", 64'(w_addr[0]), 64'd0);
    check("sad_blk0_cyc", 64'(w_cyc[0]), 64'd8);
    check("sad_blk3_addr", 64'(w_addr[3]), 64'd3);
    check("sad_blk3_sum", 64'(w_sum[3]), 64'd0);
    check("sad_blk3_cyc", 64'(w_cyc[3]), 64'd32);
    check("sad_done_cyc", 64'(done_cyc), 64'd33);
    check("sad_no_overlap", 64'(overlap), 64'd0);
    check("sad_issues", 64'(n_iss), 64'd16);
    check("sad_a_first", 64'(iss_a[0]), 64'h1000);
    check("sad_a_blk1", 64'(iss_a[4]), 64'h1004);
    check("sad_b_last_blk0", 64'(iss_b[3]), 64'h2003);
    check("sad_busy_after", 64'(m_busy), 64'd0);
    check("sad_done_once", 64'(m_done), 64'd0);

    // SSD of block 0: 4+25+0+100 = 129; Go held during the Done cycle.
    run(1'b0, 1'b1, 15'h1000, 15'h2000, 0, 1'b1);
    check("ssd_blk0", 64'(w_sum[0]), 64'd129);
    check("go_at_done_ignored", 64'(m_busy), 64'd0);
    @(negedge clk);
    check("go_after_done_taken", 64'(m_busy), 64'd1);
    go_main = 1'b0;
    n_evt = 0;
    for (int i = 0; i < 100 && n_evt == 0; i++) begin
      if (m_done) n_evt++;
      @(negedge clk);
    end
    check("retrigger_done", 64'(n_evt), 64'd1);

    // Address wrap 0x7FFF -> 0x0000; block sums 1..4, 5..8, 9..12, 13..16.
    run(1'b0, 1'b0, 15'h7FFE, 15'h0100, 0, 1'b0);
    check("wrap_a1", 64'(iss_a[1]), 64'h7FFF);
    check("wrap_a2", 64'(iss_a[2]), 64'h0000);
    check("wrap_a15", 64'(iss_a[15]), 64'h000D);
    check("wrap_b15", 64'(iss_b[15]), 64'h010F);
    check("wrap_sum0", 64'(w_sum[0]), 64'd10);
    check("wrap_sum1", 64'(w_sum[1]), 64'd26);
    check("wrap_sum2", 64'(w_sum[2]), 64'd42);
    check("wrap_sum3", 64'(w_sum[3]), 64'd58);
    check("wrap_addr2", 64'(w_addr[2]), 64'd2);

    // Block sums 50, 20, 20, 70: minimum 20 at the earlier index.
    run(1'b0, 1'b0, 15'h3000, 15'h4000, 0, 1'b0);
    check("min_sum0", 64'(w_sum[0]), 64'd50);
    check("min_sum2", 64'(w_sum[2]), 64'd20);
    check("min_sum3", 64'(w_sum[3]), 64'd70);
`ifdef SAD_MIN_TRACK_EN
    check("min_sad", 64'(min_sad_done), 64'd20);
    check("min_idx", 64'(min_idx_done), 64'd1);
`endif

    // Go pulsed mid-RUN: timing and result unchanged.
    run(1'b0, 1'b0, 15'h1000, 15'h2000, 4, 1'b0);
    check("midgo_blk0", 64'(w_sum[0]), 64'd17);
    check("midgo_done_cyc", 64'(done_cyc), 64'd33);
    check("midgo_writes", 64'(n_w), 64'd4);

    // Reset mid-RUN aborts the run.
    sel_sat = 1'b0; mode = 1'b0; a_base = 15'h1000; b_base = 15'h2000;
    @(negedge clk); go_main = 1'b1;
    @(negedge clk); go_main = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_run", 64'(m_i_en), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs", 64'({m_busy, m_i_en, m_o_en, m_done}), 64'd0);
    check("abort_addr", 64'(m_a_addr), 64'd0);
`ifdef SAD_MIN_TRACK_EN
    check("abort_min", 64'(m_min_sad), 64'd0);
`endif
    rst_n = 1'b1;
    n_evt = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_o_en || m_done || m_i_en) n_evt++;
      @(negedge clk);
    end
    check("abort_quiet", 64'(n_evt), 64'd0);
    run(1'b0, 1'b0, 15'h1000, 15'h2000, 0, 1'b0);
    check("abort_fresh", 64'(w_sum[0]), 64'd17);

    // 8-bit accumulator saturates; single-block run.
    run(1'b1, 1'b1, 15'h5000, 15'h6000, 0, 1'b0);
    check("sat_ssd", 64'(w_sum[0]), 64'd255);
    check("sat_cyc", 64'(w_cyc[0]), 64'd8);
    check("sat_done_cyc", 64'(done_cyc), 64'd9);
    run(1'b1, 1'b0, 15'h5000, 15'h6000, 0, 1'b0);
    check("sat_sad", 64'(w_sum[0]), 64'd255);
    check("sat_writes", 64'(n_w), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
